// File: rtl/mdu_if.sv
// Start/busy/done handshake and operand/result buses between the EX stage and the
// iterative multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] Op1_i;
  logic [WIDTH-1:0] Op2_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, Op1_i, Op2_i, flush_i,
    input  busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, Op1_i, Op2_i, flush_i,
    output busy_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide.
// state | meaning:  IDLE | waiting for start;  CALC | one radix-2 step per cycle;  FIX | sign fix + result write
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic   clk_i,
  input logic   rst_n_i,
  mdu_if.slave  bus
);
  localparam int W = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [2*W-1:0]   acc_q;
  logic [W:0]       rem_q;
  logic [W-1:0]     b_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;

  logic           signed_op;
  logic           op1_neg;
  logic           op2_neg;
  logic [W-1:0]   op1_mag;
  logic [W-1:0]   op2_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_d;
  logic [W+1:0]   div_trial;
  logic [W+1:0]   div_diff;
  logic [W:0]     rem_d;
  logic [W-1:0]   quo_d;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    signed_op = ~bus.op_i[0];
    op1_neg   = signed_op & bus.Op1_i[W-1];
    op2_neg   = signed_op & bus.Op2_i[W-1];
    op1_mag   = op1_neg ? -bus.Op1_i : bus.Op1_i;
    op2_mag   = op2_neg ? -bus.Op2_i : bus.Op2_i;

    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_d     = {mul_sum, acc_q[W-1:1]};

    // Borrow out of the W+2 bit subtraction means the trial remainder is below the divisor.
    div_trial = {rem_q, acc_q[W-1]};
    div_diff  = div_trial - {2'b00, b_q};
    rem_d     = div_diff[W+1] ? div_trial[W:0] : div_diff[W:0];
    quo_d     = {acc_q[W-2:0], ~div_diff[W+1]};

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.flush_i) begin
            is_div_q  <= bus.op_i[1];
            neg_res_q <= op1_neg ^ op2_neg;
            neg_rem_q <= op1_neg;
            b_q       <= op2_mag;
            rem_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b1;
            // A zero divisor skips the iterations; the raw dividend is parked for hi_o.
            if (bus.op_i[1] && (bus.Op2_i == '0)) begin
              dz_q    <= 1'b1;
              acc_q   <= {{W{1'b0}}, bus.Op1_i};
              state_q <= FIX;
            end else begin
              dz_q    <= 1'b0;
              acc_q   <= {{W{1'b0}}, op1_mag};
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (is_div_q) begin
              rem_q        <= rem_d;
              acc_q[W-1:0] <= quo_d;
            end else begin
              acc_q <= mul_d;
            end
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(W-1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!bus.flush_i) begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (dz_q) begin
              hi_q <= acc_q[W-1:0];
              lo_q <= '1;
            end else if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.div_zero_o = div_zero_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: a cycle-level reference model built on 64-bit arithmetic is
// compared every cycle, alongside directed vectors with literal expectations.
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus();

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Architectural result of one operation.
  function automatic void golden(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
    longint          sa, sb, r64;
    longint unsigned ua, ub, u64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin r64 = sa * sb; h = r64[63:32]; l = r64[31:0]; end
      2'b01: begin u64 = ua * ub; h = u64[63:32]; l = u64[31:0]; end
      default: begin
        if (b == '0) begin
          dz = 1'b1; h = a; l = '1;
        end else if (op == 2'b10) begin
          r64 = sa / sb; l = r64[31:0];
          r64 = sa % sb; h = r64[31:0];
        end else begin
          u64 = ua / ub; l = u64[31:0];
          u64 = ua % ub; h = u64[31:0];
        end
      end
    endcase
  endfunction

  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_rem;

  // Cycle model: an accepted op completes a fixed number of edges later unless flushed.
  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] gh, gl;
    logic         gdz;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (bus.flush_i) begin
          m_rem <= 0; m_busy <= 1'b0;
        end else if (m_rem == 1) begin
          m_rem <= 0; m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= p_hi; m_lo <= p_lo; m_dz <= p_dz;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (bus.start_i && !bus.flush_i) begin
        golden(bus.op_i, bus.Op1_i, bus.Op2_i, gh, gl, gdz);
        p_hi <= gh; p_lo <= gl; p_dz <= gdz;
        m_rem  <= gdz ? 1 : W + 1;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", bus.busy_o, m_busy);
      chk("cyc_done", bus.done_o, m_done);
      chk("cyc_div_zero", bus.div_zero_o, m_dz);
      chk("cyc_hi", bus.hi_o, m_hi);
      chk("cyc_lo", bus.lo_o, m_lo);
    end
  end

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_i = op; bus.Op1_i = a; bus.Op2_i = b; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.op_i = 2'($urandom);
    bus.Op1_i = $urandom;
    bus.Op2_i = $urandom;
  endtask

  // Returns on the negedge where done_o is seen; extra_at >= 0 injects a stray start.
  task automatic wait_done(input string name, input int exp_busy, input int extra_at);
    int   cnt = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o) begin seen = 1'b1; break; end
      if (bus.busy_o) cnt++;
      if (i == extra_at) begin
        bus.start_i = 1'b1; bus.op_i = 2'b10; bus.Op1_i = 32'h1234; bus.Op2_i = 32'h5;
      end else begin
        bus.start_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk({name, "_done_seen"}, seen, 1'b1);
    chk({name, "_busy_cycles"}, cnt, exp_busy);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                     input int exp_busy, input int extra_at);
    start_op(op, a, b);
    wait_done(name, exp_busy, extra_at);
    chk({name, "_hi"}, bus.hi_o, eh);
    chk({name, "_lo"}, bus.lo_o, el);
    chk({name, "_div_zero"}, bus.div_zero_o, edz);
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    logic saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done_o) saw = 1'b1;
    end
    chk(name, saw, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.Op1_i = '0; bus.Op2_i = '0; bus.flush_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_hi", bus.hi_o, 32'h0);
    chk("rst_lo", bus.lo_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run("mult_neg",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, -1);
    @(negedge clk);
    run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 5);
    @(negedge clk);
    run("div_neg",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, -1);
    @(negedge clk);
    run("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, -1);
    @(negedge clk);
    run("divu_zero", 2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1, -1);
    // Issued in the done cycle of the previous op.
    run("divu_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, -1);
    @(negedge clk);

    start_op(2'b00, 32'd12345, 32'd678);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_busy", bus.busy_o, 1'b0);
    watch_no_done("flush_no_done", 40);
    chk("flush_hi", bus.hi_o, 32'd2);
    chk("flush_lo", bus.lo_o, 32'd14);

    bus.flush_i = 1'b1; bus.start_i = 1'b1; bus.op_i = 2'b01; bus.Op1_i = 32'd3; bus.Op2_i = 32'd3;
    @(negedge clk);
    bus.flush_i = 1'b0; bus.start_i = 1'b0;
    chk("flush_start_busy", bus.busy_o, 1'b0);
    @(negedge clk);

    start_op(2'b10, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy_o, 1'b0);
    chk("arst_hi", bus.hi_o, 32'h0);
    chk("arst_lo", bus.lo_o, 32'h0);
    chk("arst_done", bus.done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("arst_no_done", 40);
    run("multu_67", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, -1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the EX stage.
- Consumes the same forwarded operand buses that feed the single-cycle ALU.
- Its HI/LO results are merged into the EX result mux downstream of the ALU. It replaces the ALU's one-cycle MUL/DIV paths for MULT/MULTU/DIV/DIVU.
- Uses a start/busy/done handshake; the hazard unit stalls the pipeline while busy_o is high.

Parameters:
- WIDTH, 32, operand width; hi_o/lo_o are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  launch request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Op1_i  in  WIDTH  multiplicand / dividend.
- Op2_i  in  WIDTH  multiplier / divisor.
- flush_i  in  1  synchronous abort from the pipeline flush logic.
- busy_o  out  1  operation in progress; the stall request.
- done_o  out  1  one-cycle pulse when hi_o/lo_o have just been updated.
- div_zero_o  out  1  valid with done_o; a DIV/DIVU had divisor 0.
- hi_o  out  WIDTH  product upper half / remainder.
- lo_o  out  WIDTH  product lower half / quotient.

Behaviour:

Clock and reset:
- Single clock domain.
- rst_n_i low forces, at any time and asynchronously: state=IDLE, count=0, busy_o=0, done_o=0, div_zero_o=0, hi_o=0, lo_o=0, all internal datapath registers 0.
- Reset during an operation discards it; no done_o follows.

States:
- IDLE: busy_o=0.
  - start_i=1 at edge k: latch op, |Op1_i| and |Op2_i|, and the result sign flags; go to CALC with count=0.
  - Magnitudes are taken only for signed ops (MULT/DIV); for MULTU/DIVU the raw operands are latched.
  - DIV/DIVU with Op2_i==0 goes to FIX instead of CALC.
  - start_i=0: stay in IDLE.
- CALC: one radix-2 step per cycle, count increments each cycle. Leaves to FIX after the step with count==WIDTH-1, i.e. exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. The partial remainder is WIDTH+1 bits so that the 0x80000000 magnitude is handled.
- FIX: apply sign correction, write hi_o/lo_o, set done_o=1 for this edge only, return to IDLE.

busy_o and done_o timing:
- busy_o is registered. It is high after edge k through the edge that leaves FIX.
- Normal op: busy_o is high for WIDTH+1 cycles. hi_o/lo_o and done_o update at edge k+WIDTH+1.
- Divide by zero: busy_o is high for 1 cycle; done_o is at edge k+1.
- done_o and busy_o are never high in the same cycle.

Sign rules:
- Signed product is negated if the operand signs differ.
- Signed quotient is negated if the signs differ.
- Remainder takes the sign of the dividend.
- -2^(WIDTH-1) / -1 yields lo=0x80000000, hi=0 with no exception flag.

Divide by zero:
- lo_o = all ones, hi_o = Op1_i (unmodified), div_zero_o=1 alongside done_o.
- div_zero_o clears on the next done_o or on reset.

Handshake and flush:
- start_i while busy_o=1 is ignored.
- start_i in the cycle done_o=1 is accepted; the unit is in IDLE then.
- Operand inputs are don't-care after the start edge.
- flush_i=1 in CALC or FIX: return to IDLE at the next edge; hi_o/lo_o unchanged; no done_o.
- flush_i has priority over the FIX write.
- flush_i together with start_i in IDLE: start is dropped.

Output holding:
- hi_o/lo_o hold their value between operations.

Test Plan:
- MULT Op1=0xFFFFFFFD (-3), Op2=5, start pulse -> busy_o high 33 cycles, then done_o one cycle with hi=0xFFFFFFFF, lo=0xFFFFFFF1, div_zero_o=0.
- MULTU Op1=Op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 33-cycle busy.
- DIV Op1=0xFFFFFFF9 (-7), Op2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU Op1=100, Op2=0 -> busy_o 1 cycle, done_o next edge, lo=0xFFFFFFFF, hi=100, div_zero_o=1. A following DIVU 100/7 -> lo=14, hi=2, div_zero_o=0.
- Second start_i asserted mid-operation is ignored.
- flush_i asserted at CALC cycle 10 of a MULT -> next cycle busy_o=0, no done_o, hi/lo keep the prior values.
- rst_n_i pulled low asynchronously mid-DIV -> outputs 0 immediately. After release, a fresh MULTU 6*7 gives lo=42, hi=0.
